xmul_share_arbiter: RTL and testbench

- Shares one pipelined approximate ("fake") multiplier among NREQ requesters, e.g. the gradient/orientation stages of the SIFT pipeline.
- Approximate product: sign = XOR of operand signs; magnitude = min(|in1|, |in2|).
- Round-robin arbitration with valid/ready on every requester port; one tagged result stream with backpressure.
- Throughput is one product per cycle; latency is fixed when there is no stall.

---
 rtl/xmul_share_arbiter_pkg.sv | 44 ++++
 rtl/xmul_share_arbiter_core.sv | 45 ++++
 rtl/xmul_share_arbiter.sv | 125 ++++++++++++
 tb/tb_xmul_share_arbiter.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/xmul_share_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// xmul_share_arbiter_pkg
// Shared helpers for the approximate-multiplier arbiter:
//   absWidth  - magnitude width of a signed operand (sign bit dropped).
//   rrSearch  - round-robin search of a request vector starting at a pointer,
//               wrapping modulo nReq (up to maxReq requesters).
// No ports; imported by xmul_core and xmul_share_arbiter.
// -----------------------------------------------------------------------------
package xmul_share_arbiter_pkg;

    localparam int maxReq = 16;

    // Magnitude of a dataW-bit two's-complement value kept in dataW-1 bits.
    function automatic int absWidth(input int dataW);
        return dataW - 1;
    endfunction

    // Returns the index of the first set bit of valid at or after ptr,
    // wrapping at nReq. found is low when no bit below nReq is set.
    function automatic int rrSearch(input logic [maxReq-1:0] valid,
                                    input int               ptr,
                                    input int               nReq,
                                    output logic            found);
        int grant;
        int idx;
        grant = 0;
        found = 1'b0;
        for (int k = 0; k < maxReq; k++) begin
            if (k < nReq && !found) begin
                // ptr < nReq and k < nReq, so one subtraction wraps the index.
                idx = ptr + k;
                if (idx >= nReq) begin
                    idx = idx - nReq;
                end
                if (valid[idx[3:0]]) begin
                    found = 1'b1;
                    grant = idx;
                end
            end
        end
        return grant;
    endfunction

endpackage

// File: rtl/xmul_share_arbiter_core.sv
// -----------------------------------------------------------------------------
// xmul_core
// Combinational approximate ("fake") multiply:
//   sign      = in1 sign XOR in2 sign
//   magnitude = min(|in1|, |in2|), |x| truncated to dataW-1 bits
//   outData   = sign ? -magnitude : magnitude   (outW bits)
// Ports:
//   in1, in2  [dataW-1:0]  signed operands
//   outData   [outW-1:0]   signed approximate product
// -----------------------------------------------------------------------------
module xmul_core
    import xmul_share_arbiter_pkg::*;
#(
    parameter int dataW = 8,
    parameter int outW  = dataW
) (
    input  logic [dataW-1:0] in1,
    input  logic [dataW-1:0] in2,
    output logic [outW-1:0]  outData
);

    localparam int absW = absWidth(dataW);

    logic            prodSign;
    logic [absW-1:0] abs1;
    logic [absW-1:0] abs2;
    logic [absW-1:0] mag;
    logic [outW-1:0] magExt;

    // NOTE: every signal driven here gets a value on every path, so no latch
    // is inferred; blocking '=' is correct inside combinational blocks.
    always_comb begin
        prodSign = in1[dataW-1] ^ in2[dataW-1];
        // Negation modulo 2^absW only depends on the low absW bits, so the
        // most negative input folds to magnitude 0 as intended.
        abs1 = in1[dataW-1] ? -in1[absW-1:0] : in1[absW-1:0];
        abs2 = in2[dataW-1] ? -in2[absW-1:0] : in2[absW-1:0];
        mag  = (abs1 < abs2) ? abs1 : abs2;
        magExt = '0;
        magExt[absW-1:0] = mag;
        // A zero magnitude with a negative sign still yields 0.
        outData = prodSign ? -magExt : magExt;
    end

endmodule

// File: rtl/xmul_share_arbiter.sv
// -----------------------------------------------------------------------------
// xmul_share_arbiter
// Shares one two-stage approximate multiplier among NREQ requesters with
// round-robin arbitration. S1 registers the granted operand pair and its id,
// S2 is the output register. One result per cycle, latency one cycle after
// acceptance, full backpressure from resp_ready.
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   req_valid [NREQ]      requester i presents an operand pair
//   req_ready [NREQ]      one-hot grant: pair accepted this cycle
//   req_in1/req_in2       packed operands, requester i at [i*dataW +: dataW]
//   resp_valid/resp_ready result handshake
//   resp_data [outW]      signed approximate product
//   resp_id   [IDW]       requester that owns the result
// -----------------------------------------------------------------------------
module xmul_share_arbiter
    import xmul_share_arbiter_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int dataW = 8,
    parameter int outW  = dataW,
    parameter int IDW   = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*dataW-1:0] req_in1,
    input  logic [NREQ*dataW-1:0] req_in2,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [outW-1:0]       resp_data,
    output logic [IDW-1:0]        resp_id
);

    // S1 stage
    logic             s1Valid;
    logic [dataW-1:0] s1In1;
    logic [dataW-1:0] s1In2;
    logic [IDW-1:0]   s1Id;

    // Arbitration and flow control
    logic              adv1;
    logic              adv2;
    logic              grantFound;
    logic              accept;
    logic [maxReq-1:0] validPad;
    int                grantInt;
    int                nextInt;
    logic [IDW-1:0]    grantId;
    logic [IDW-1:0]    nextPtr;
    logic [IDW-1:0]    rrPtr;

    logic [outW-1:0]   coreOut;

    always_comb begin
        adv2 = !resp_valid || resp_ready;
        adv1 = !s1Valid || adv2;

        validPad = '0;
        validPad[NREQ-1:0] = req_valid;
        grantInt = rrSearch(validPad, int'(rrPtr), NREQ, grantFound);
        grantId  = IDW'(grantInt);

        // Grant is combinational on req_valid; a transfer only happens when
        // S1 can take it and reset is not active.
        accept = grantFound && adv1 && !rst;
        req_ready = '0;
        if (accept) begin
            req_ready[grantId] = 1'b1;
        end

        nextInt = grantInt + 1;
        if (nextInt == NREQ) begin
            nextInt = 0;
        end
        nextPtr = IDW'(nextInt);
    end

    xmul_core #(
        .dataW (dataW),
        .outW  (outW)
    ) uCore (
        .in1     (s1In1),
        .in2     (s1In2),
        .outData (coreOut)
    );

    // NOTE: sequential state uses non-blocking '<=' so every register samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1Valid    <= 1'b0;
            s1Id       <= '0;
            rrPtr      <= '0;
            resp_valid <= 1'b0;
            resp_data  <= '0;
            resp_id    <= '0;
        end else begin
            // S2 refills whenever it is empty or its result is leaving.
            if (adv2) begin
                resp_valid <= s1Valid;
                resp_id    <= s1Id;
                resp_data  <= coreOut;
            end
            if (accept) begin
                s1Valid <= 1'b1;
                s1Id    <= grantId;
                rrPtr   <= nextPtr;
            end else if (adv1) begin
                s1Valid <= 1'b0;
            end
        end
    end

    // NOTE: operand registers carry no reset; they are qualified by s1Valid,
    // so their content after reset is never observed.
    always_ff @(posedge clk) begin
        if (accept) begin
            s1In1 <= req_in1[grantId*dataW +: dataW];
            s1In2 <= req_in2[grantId*dataW +: dataW];
        end
    end

endmodule

// File: tb/tb_xmul_share_arbiter.sv
// -----------------------------------------------------------------------------
// tb_xmul_share_arbiter
// Self-checking bench for xmul_share_arbiter (NREQ=4, dataW=outW=8).
// Table-driven arithmetic vectors, directed multi-cycle sequences, and a
// scoreboard that queues the model product at every accepted request and
// compares it against every result leaving the DUT.
// -----------------------------------------------------------------------------
module tb_xmul_share_arbiter;

    localparam int N = 4;
    localparam int W = 8;

    logic           clk;
    logic           rst;
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_ready;
    logic [N*W-1:0] req_in1;
    logic [N*W-1:0] req_in2;
    logic           resp_valid;
    logic           resp_ready;
    logic [W-1:0]   resp_data;
    logic [1:0]     resp_id;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [1:0] id;
        logic [7:0] data;
    } exp_t;

    typedef struct {
        logic [7:0] in1;
        logic [7:0] in2;
        logic [1:0] id;
        logic [7:0] expData;
    } vec_t;

    exp_t sbQ[$];
    vec_t vecs[10];
    logic [7:0] heldData;

    xmul_share_arbiter #(
        .NREQ  (N),
        .dataW (W),
        .outW  (W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_in1    (req_in1),
        .req_in2    (req_in2),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .resp_id    (resp_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, expv, $time);
        end
    endtask

    // Reference product computed with integer arithmetic.
    function automatic logic [7:0] fakeMul(input logic [7:0] a, input logic [7:0] b);
        int ia, ib, ma, mb, m;
        ia = int'($signed(a));
        ib = int'($signed(b));
        ma = (ia < 0) ? -ia : ia;
        mb = (ib < 0) ? -ib : ib;
        if (ma > 127) ma = 0;
        if (mb > 127) mb = 0;
        m = (ma < mb) ? ma : mb;
        if ((ia < 0) != (ib < 0)) m = -m;
        return 8'(m);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic setOp(input int i, input logic [7:0] a, input logic [7:0] b);
        req_in1[i*W +: W] = a;
        req_in2[i*W +: W] = b;
    endtask

    task automatic doReset();
        rst = 1'b1;
        req_valid = '0;
        resp_ready = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic drain(input string name);
        req_valid = '0;
        resp_ready = 1'b1;
        for (int c = 0; c < 20 && sbQ.size() != 0; c++) begin
            step();
        end
        check(name, sbQ.size(), 0);
    endtask

    // Scoreboard: results are compared first, then the requests accepted at
    // the coming edge are queued. Reset discards everything in flight.
    always @(negedge clk) begin
        exp_t e;
        if (resp_valid && resp_ready) begin
            if (sbQ.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected: got id %0d data 0x%0h, expected no result at %0t",
                         resp_id, resp_data, $time);
            end else begin
                e = sbQ.pop_front();
                check("sb_id", 32'(resp_id), 32'(e.id));
                check("sb_data", 32'(resp_data), 32'(e.data));
            end
        end
        if (rst) begin
            sbQ.delete();
        end else begin
            for (int i = 0; i < N; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    e.id = 2'(i);
                    e.data = fakeMul(req_in1[i*W +: W], req_in2[i*W +: W]);
                    sbQ.push_back(e);
                end
            end
        end
    end

    initial begin
        vecs[0] = '{8'h64, 8'hEC, 2'd0, 8'hEC}; // 100 x -20   -> -20
        vecs[1] = '{8'h80, 8'h05, 2'd1, 8'h00}; // -128 x 5    -> 0
        vecs[2] = '{8'hF9, 8'hF7, 2'd2, 8'h07}; // -7 x -9     -> 7
        vecs[3] = '{8'h00, 8'hCE, 2'd3, 8'h00}; // 0 x -50     -> 0
        vecs[4] = '{8'hFD, 8'h05, 2'd0, 8'hFD}; // -3 x 5      -> -3
        vecs[5] = '{8'h7F, 8'h80, 2'd1, 8'h00}; // 127 x -128  -> 0
        vecs[6] = '{8'h9C, 8'h9C, 2'd2, 8'h64}; // -100 x -100 -> 100
        vecs[7] = '{8'hFF, 8'h7F, 2'd3, 8'hFF}; // -1 x 127    -> -1
        vecs[8] = '{8'h32, 8'h3C, 2'd0, 8'h32}; // 50 x 60     -> 50
        vecs[9] = '{8'h80, 8'h80, 2'd1, 8'h00}; // -128 x -128 -> 0

        rst = 1'b1;
        req_valid = '1;
        req_in1 = '0;
        req_in2 = '0;
        resp_ready = 1'b1;

        // Reset state, with every requester asking.
        step();
        step();
        @(negedge clk);
        check("rst_req_ready", 32'(req_ready), 0);
        check("rst_resp_valid", 32'(resp_valid), 0);
        check("rst_resp_data", 32'(resp_data), 0);
        check("rst_resp_id", 32'(resp_id), 0);
        step();
        rst = 1'b0;
        req_valid = '0;

        // Single request: grant same cycle, result one cycle after acceptance.
        setOp(2, 8'hFD, 8'h05);
        req_valid = 4'b0100;
        @(negedge clk);
        check("single_ready", 32'(req_ready), 32'h4);
        step();
        req_valid = '0;
        @(negedge clk);
        check("single_not_yet", 32'(resp_valid), 0);
        step();
        @(negedge clk);
        check("single_valid", 32'(resp_valid), 1);
        check("single_data", 32'(resp_data), 32'hFD);
        check("single_id", 32'(resp_id), 2);
        drain("single_drain");

        // Arithmetic table, one requester at a time.
        for (int v = 0; v < 10; v++) begin
            setOp(int'(vecs[v].id), vecs[v].in1, vecs[v].in2);
            req_valid = 4'(1 << vecs[v].id);
            @(negedge clk);
            check("vec_ready", 32'(req_ready), 32'(1 << vecs[v].id));
            step();
            req_valid = '0;
            step();
            @(negedge clk);
            check("vec_valid", 32'(resp_valid), 1);
            check("vec_data", 32'(resp_data), 32'(vecs[v].expData));
            check("vec_id", 32'(resp_id), 32'(vecs[v].id));
            step();
        end
        drain("vec_drain");

        // Full contention from reset: ids rotate 0,1,2,3 with no bubbles.
        doReset();
        for (int i = 0; i < N; i++) begin
            setOp(i, 8'(i * 10 + 1), 8'(-(i * 10 + 5)));
        end
        req_valid = '1;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            check("cont_ready", 32'(req_ready), 32'(1 << (k % 4)));
            if (k >= 2) begin
                check("cont_resp", 32'({resp_valid, resp_id}), 32'({1'b1, 2'((k - 2) % 4)}));
            end
            step();
        end
        drain("cont_drain");

        // Backpressure: two pairs in flight, output stalled for three cycles.
        doReset();
        setOp(0, 8'h1E, 8'hF0); // 30 x -16  -> 0xF0
        setOp(1, 8'h05, 8'h40); // 5 x 64    -> 0x05
        setOp(2, 8'hE2, 8'hE2); // -30 x -30 -> 0x1E
        req_valid = 4'b0011;
        @(negedge clk);
        check("bp_ready0", 32'(req_ready), 32'h1);
        step();
        @(negedge clk);
        check("bp_ready1", 32'(req_ready), 32'h2);
        step();
        resp_ready = 1'b0;
        req_valid = 4'b0100;
        heldData = 8'hF0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("bp_hold_valid", 32'(resp_valid), 1);
            check("bp_hold_id", 32'(resp_id), 0);
            check("bp_hold_data", 32'(resp_data), 32'(heldData));
            check("bp_no_ready", 32'(req_ready), 0);
            step();
        end
        resp_ready = 1'b1;
        @(negedge clk);
        check("bp_release_ready", 32'(req_ready), 32'h4);
        check("bp_release_id", 32'(resp_id), 0);
        step();
        req_valid = '0;
        @(negedge clk);
        check("bp_order1_id", 32'(resp_id), 1);
        check("bp_order1_data", 32'(resp_data), 32'h05);
        step();
        @(negedge clk);
        check("bp_order2_id", 32'(resp_id), 2);
        check("bp_order2_data", 32'(resp_data), 32'h1E);
        drain("bp_drain");

        // Round robin: pointer wraps from 3 to 0.
        doReset();
        setOp(3, 8'h11, 8'h22);
        setOp(0, 8'h33, 8'h44);
        req_valid = 4'b1000;
        @(negedge clk);
        check("rr_only3", 32'(req_ready), 32'h8);
        step();
        req_valid = 4'b1001;
        @(negedge clk);
        check("rr_wrap_to0", 32'(req_ready), 32'h1);
        step();
        @(negedge clk);
        check("rr_then3", 32'(req_ready), 32'h8);
        step();
        req_valid = '0;
        drain("rr_drain_a");

        // Round robin: after granting 1, requester 3 beats requester 0.
        doReset();
        setOp(1, 8'h0A, 8'hF6);
        req_valid = 4'b0010;
        @(negedge clk);
        check("rr_only1", 32'(req_ready), 32'h2);
        step();
        req_valid = 4'b1001;
        @(negedge clk);
        check("rr_ptr2_to3", 32'(req_ready), 32'h8);
        step();
        @(negedge clk);
        check("rr_then0", 32'(req_ready), 32'h1);
        step();
        req_valid = '0;
        drain("rr_drain_b");

        // Reset with S1 and S2 both full: nothing from before survives.
        doReset();
        setOp(0, 8'h10, 8'h20);
        setOp(1, 8'h11, 8'h22);
        req_valid = 4'b0011;
        step();
        step();
        resp_ready = 1'b0;
        rst = 1'b1;
        req_valid = '1;
        @(negedge clk);
        check("mid_rst_full", 32'(resp_valid), 1);
        check("mid_rst_ready", 32'(req_ready), 0);
        step();
        rst = 1'b0;
        resp_ready = 1'b1;
        setOp(0, 8'h03, 8'h7F);
        @(negedge clk);
        check("mid_rst_flushed", 32'(resp_valid), 0);
        check("mid_rst_ptr0", 32'(req_ready), 32'h1);
        step();
        req_valid = '0;
        @(negedge clk);
        check("mid_rst_s1only", 32'(resp_valid), 0);
        step();
        @(negedge clk);
        check("mid_rst_new_valid", 32'(resp_valid), 1);
        check("mid_rst_new_id", 32'(resp_id), 0);
        check("mid_rst_new_data", 32'(resp_data), 32'h03);
        drain("mid_rst_drain");

        step();
        step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
